// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC (ALU settles) -> WB (done pulse to owner).
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] r0,
    input  logic [DATA_W-1:0] s0,
    input  logic [OP_W-1:0]   op0,
    input  logic              req1,
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] s1,
    input  logic [OP_W-1:0]   op1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] alu_r,
    output logic [DATA_W-1:0] alu_s,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic [DATA_W-1:0] y,
    output logic              n,
    output logic              z,
    output logic              c,
    output logic              done0,
    output logic              done1,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   alu_r_q, alu_r_d;
    logic [DATA_W-1:0]   alu_s_q, alu_s_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                n_q, n_d, z_q, z_d, c_q, c_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                busy_q, busy_d;

    // Handshake: reqN is a valid, gntN is its ready; the operation transfers on a
    // rising edge where both are high, and the requester may change or drop it after.
    always_comb begin
        gnt0 = (state_q == IDLE) && req0 && (!req1 || last_q);
        gnt1 = (state_q == IDLE) && req1 && (!req0 || !last_q);
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        alu_r_d  = alu_r_q;
        alu_s_d  = alu_s_q;
        alu_op_d = alu_op_q;
        y_d      = y_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    alu_r_d  = gnt1 ? r1 : r0;
                    alu_s_d  = gnt1 ? s1 : s0;
                    alu_op_d = gnt1 ? op1 : op0;
                    owner_d  = gnt1;
                    last_d   = gnt1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                y_d     = alu_y;
                n_d     = alu_n;
                z_d     = alu_z;
                c_d     = alu_c;
                done0_d = !owner_q;
                done1_d = owner_q;
                state_d = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            alu_r_q  <= '0;
            alu_s_q  <= '0;
            alu_op_q <= '0;
            y_q      <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            alu_r_q  <= alu_r_d;
            alu_s_q  <= alu_s_d;
            alu_op_q <= alu_op_d;
            y_q      <= y_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    assign alu_r     = alu_r_q;
    assign alu_s     = alu_s_q;
    assign alu_op    = alu_op_q;
    assign y         = y_q;
    assign n         = n_q;
    assign z         = z_q;
    assign c         = c_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU, a cycle model of the arbiter, vector
// table, corner-case sequences and randomized traffic.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] r0 = '0, s0 = '0, r1 = '0, s1 = '0;
    logic [3:0]  op0 = '0, op1 = '0;
    logic        gnt0, gnt1;
    logic [15:0] alu_r, alu_s, alu_y, y;
    logic [3:0]  alu_op;
    logic        alu_n, alu_z, alu_c, n, z, c;
    logic        done0, done1, busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(16), .OP_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .r0(r0), .s0(s0), .op0(op0),
        .req1(req1), .r1(r1), .s1(s1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_r(alu_r), .alu_s(alu_s), .alu_op(alu_op),
        .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
        .y(y), .n(n), .z(z), .c(c),
        .done0(done0), .done1(done1), .busy(busy), .state_dbg(state_dbg)
    );

    // Reference ALU: returns {n, z, c, y}; undefined opcodes pass S.
    function automatic logic [18:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        case (op)
            4'd0:    t = {1'b0, a};
            4'd1:    t = {1'b0, b};
            4'd2:    t = {1'b0, b} + 17'd1;
            4'd3:    t = {1'b0, b} - 17'd1;
            4'd4:    t = {1'b0, a} + {1'b0, b};
            4'd5:    t = {1'b0, a} - {1'b0, b};
            4'd6:    t = {1'b0, b} - {1'b0, a};
            4'd7:    t = {b, 1'b0};
            4'd8:    t = {1'b0, a & b};
            4'd9:    t = {1'b0, a | b};
            4'd10:   t = {1'b0, a ^ b};
            4'd11:   t = {1'b0, ~b};
            4'd12:   t = {1'b0, ~a};
            default: t = {1'b0, b};
        endcase
        return {t[15], (t[15:0] == 16'h0), t[16], t[15:0]};
    endfunction

    always_comb {alu_n, alu_z, alu_c, alu_y} = alu_ref(alu_op, alu_r, alu_s);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: phase counts cycles since accept (0 = idle, 1 = executing, 2 = writeback).
    int          m_phase = 0;
    logic        m_last = 1'b1, m_owner = 1'b0;
    logic [15:0] m_r = '0, m_s = '0, m_y = '0;
    logic [3:0]  m_op = '0;
    logic        m_n = 1'b0, m_z = 1'b0, m_c = 1'b0;
    logic        e_g0, e_g1;

    assign e_g0 = (m_phase == 0) && req0 && (!req1 || m_last);
    assign e_g1 = (m_phase == 0) && req1 && (!req0 || !m_last);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_phase <= 0; m_last <= 1'b1; m_owner <= 1'b0;
            m_r <= '0; m_s <= '0; m_op <= '0;
            m_y <= '0; m_n <= 1'b0; m_z <= 1'b0; m_c <= 1'b0;
        end else if (m_phase == 0) begin
            if (e_g0 || e_g1) begin
                m_phase <= 1;
                m_owner <= e_g1;
                m_last  <= e_g1;
                m_r     <= e_g1 ? r1 : r0;
                m_s     <= e_g1 ? s1 : s0;
                m_op    <= e_g1 ? op1 : op0;
            end
        end else if (m_phase == 1) begin
            {m_n, m_z, m_c, m_y} <= alu_ref(m_op, m_r, m_s);
            m_phase <= 2;
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt0", gnt0, e_g0);
            chk("gnt1", gnt1, e_g1);
            chk("alu_r", alu_r, m_r);
            chk("alu_s", alu_s, m_s);
            chk("alu_op", alu_op, m_op);
            chk("y", y, m_y);
            chk("nzc", {n, z, c}, {m_n, m_z, m_c});
            chk("done0", done0, (m_phase == 2) && !m_owner);
            chk("done1", done1, (m_phase == 2) && m_owner);
            chk("busy", busy, m_phase != 0);
        end
    end

    typedef struct {
        logic        use1;
        logic [15:0] r;
        logic [15:0] s;
        logic [3:0]  op;
        logic [15:0] ey;
        logic        en, ez, ec;
    } vec_t;

    vec_t tbl[7];

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Waits (bounded) for the next done pulse and reports which one and the payload.
    task automatic wait_done(output logic d0, output logic d1, output logic [18:0] res, output int at);
        d0 = 1'b0; d1 = 1'b0; res = '0; at = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                d0 = done0; d1 = done1; res = {n, z, c, y}; at = cyc;
                return;
            end
        end
        chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic        d0, d1;
        logic [18:0] res;
        int          at;
        @(posedge clk); #1;
        r0 = $urandom; s0 = $urandom; op0 = $urandom_range(0, 15);
        r1 = $urandom; s1 = $urandom; op1 = $urandom_range(0, 15);
        if (v.use1) begin req1 = 1'b1; r1 = v.r; s1 = v.s; op1 = v.op; end
        else        begin req0 = 1'b1; r0 = v.r; s0 = v.s; op0 = v.op; end
        @(negedge clk);
        chk($sformatf("vec%0d_gnt", idx), {gnt1, gnt0}, v.use1 ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0; r0 = $urandom; r1 = $urandom;
        wait_done(d0, d1, res, at);
        chk($sformatf("vec%0d_done", idx), {d1, d0}, v.use1 ? 2'b10 : 2'b01);
        chk($sformatf("vec%0d_res", idx), res, {v.en, v.ez, v.ec, v.ey});
    endtask

    logic        d0, d1;
    logic [18:0] res;
    int          at, prev_at, idle_cnt;
    logic [0:0]  own_q[$];
    logic [15:0] exp_q[$];

    initial begin
        tbl[0] = '{1'b0, 16'h0005, 16'h0003, 4'b0101, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'h0003, 16'h0005, 4'b0101, 16'hFFFE, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 16'h0005, 16'h0003, 4'b0100, 16'h0008, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'h00FF, 16'h0F0F, 4'b1000, 16'h000F, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 16'h1234, 16'hABCD, 4'b1111, 16'hABCD, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 16'h7777, 16'h0000, 4'b0011, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 16'hFFFF, 4'b0010, 16'h0000, 1'b0, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_y", y, 16'h0);
        chk("rst_busy_done", {busy, done0, done1}, 3'b000);
        chk("rst_alu_op", alu_op, 4'h0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // Result holds while idle.
        repeat (4) begin
            @(negedge clk);
            chk("hold_res", {n, z, c, y}, {1'b0, 1'b1, 1'b1, 16'h0000});
        end

        // Fairness: both held, grants alternate starting with requester 0 after reset.
        do_reset();
        r0 = 16'h0005; s0 = 16'h0003; op0 = 4'b0100;
        r1 = 16'h00FF; s1 = 16'h0F0F; op1 = 4'b1000;
        req0 = 1'b1; req1 = 1'b1;
        own_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_q = '{16'h0008, 16'h000F, 16'h0008, 16'h000F};
        prev_at = -1;
        while (own_q.size() > 0) begin
            wait_done(d0, d1, res, at);
            chk("fair_owner", {d1, d0}, own_q[0] ? 2'b10 : 2'b01);
            chk("fair_y", res[15:0], exp_q[0]);
            if (prev_at >= 0) chk("fair_gap", at - prev_at, 3);
            prev_at = at;
            void'(own_q.pop_front());
            void'(exp_q.pop_front());
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset during EXEC of a requester 1 operation.
        do_reset();
        req1 = 1'b1; r1 = 16'h0003; s1 = 16'h0005; op1 = 4'b0101;
        @(negedge clk);
        chk("rx_gnt1", gnt1, 1'b1);
        @(posedge clk); #1;
        req1 = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rx_in_exec", busy, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rx_outs", {alu_r, alu_s, alu_op, y, n, z, c, done0, done1, busy}, 58'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rx_no_done1", done1, 1'b0);
        end
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1;
        wait_done(d0, d1, res, at);
        chk("rx_first_owner", {d1, d0}, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(posedge clk);

        // Re-accept: req0 held across its own done; busy low for one cycle only.
        #1 req0 = 1'b1; r0 = 16'h0001; s0 = 16'h0002; op0 = 4'b0100;
        wait_done(d0, d1, res, prev_at);
        idle_cnt = 0;
        at = -1;
        for (int i = 0; i < 10 && at < 0; i++) begin
            @(negedge clk);
            if (!busy) idle_cnt++;
            if (done0 || done1) at = cyc;
        end
        chk("reacc_seen", at >= 0, 1'b1);
        chk("reacc_gap", at - prev_at, 3);
        chk("reacc_idle", idle_cnt, 1);
        @(posedge clk); #1 req0 = 1'b0;

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req0 = $urandom_range(0, 1); req1 = $urandom_range(0, 1);
            r0 = $urandom; s0 = $urandom; op0 = $urandom_range(0, 15);
            r1 = $urandom; s1 = $urandom; op1 = $urandom_range(0, 15);
            reset = ($urandom_range(0, 40) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
